// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the
// instruction fetch queue.
package fetch_pkg;

  localparam int DEF_INST_W = 32;
  localparam int DEF_DEPTH  = 64;
  localparam int DEF_ENQ_W  = 2;
  localparam int DEF_DEQ_W  = 2;

  localparam int ENQ_CNT_W = $clog2(DEF_ENQ_W + 1);
  localparam int DEQ_CNT_W = $clog2(DEF_DEQ_W + 1);

  typedef logic [0:DEF_INST_W-1] inst_t;

endpackage

// File: rtl/iq_storage.sv
// Circular entry array: ENQ_W write lanes at
// tail+i, DEQ_W combinational read lanes at head+i.
module iq_storage #(
  parameter int INST_W = 32,
  parameter int DEPTH  = 64,
  parameter int ENQ_W  = 2,
  parameter int DEQ_W  = 2,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic [ENQ_W-1:0]        we,
  input  logic [PTR_W-1:0]        tail,
  input  logic [ENQ_W*INST_W-1:0] wdata,
  input  logic [PTR_W-1:0]        head,
  output logic [DEQ_W*INST_W-1:0] rdata
);

  logic [INST_W-1:0] mem [DEPTH];

  // Lane writes; contents are never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENQ_W; i++) begin
      if (we[i]) begin
        mem[tail + PTR_W'(i)] <=
          wdata[i*INST_W +: INST_W];
      end
    end
  end

  // Oldest DEQ_W entries, read before any write.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < DEQ_W; i++) begin
      rdata[i*INST_W +: INST_W] =
        mem[head + PTR_W'(i)];
    end
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch-to-decode circular queue with explicit
// occupancy, all-or-nothing enqueue and flush.
module inst_fetch_queue #(
  parameter int INST_W = fetch_pkg::DEF_INST_W,
  parameter int DEPTH  = fetch_pkg::DEF_DEPTH,
  parameter int ENQ_W  = fetch_pkg::DEF_ENQ_W,
  parameter int DEQ_W  = fetch_pkg::DEF_DEQ_W,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       enq_valid,
  input  logic [$clog2(ENQ_W+1)-1:0] enq_count,
  input  logic [ENQ_W*INST_W-1:0]    enq_data,
  output logic                       enq_ready,
  output logic [DEQ_W*INST_W-1:0]    deq_data,
  output logic [DEQ_W-1:0]           deq_valid,
  input  logic [$clog2(DEQ_W+1)-1:0] deq_take,
  output logic [CNT_W-1:0]           count,
  output logic                       err_overtake
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ECW   = $clog2(ENQ_W + 1);

  logic [PTR_W-1:0]        head;
  logic [PTR_W-1:0]        tail;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        enq_n;
  logic [CNT_W-1:0]        nvalid;
  logic [CNT_W-1:0]        take_req;
  logic [CNT_W-1:0]        take;
  logic                    enq_ok;
  logic                    overtake;
  logic [ENQ_W-1:0]        we;
  logic [DEQ_W*INST_W-1:0] rdata;

  assign count     = cnt;
  assign enq_ready =
    (CNT_W'(DEPTH) - cnt) >= CNT_W'(ENQ_W);

  // Enqueue acceptance and clamped dequeue amount.
  always_comb begin
    enq_ok   = enq_valid && enq_ready && !flush
            && (enq_count != '0)
            && (enq_count <= ECW'(ENQ_W));
    enq_n    = enq_ok ? CNT_W'(enq_count) : '0;
    nvalid   = (cnt > CNT_W'(DEQ_W))
             ? CNT_W'(DEQ_W) : cnt;
    take_req = CNT_W'(deq_take);
    overtake = take_req > nvalid;
    take     = overtake ? nvalid : take_req;
    for (int i = 0; i < ENQ_W; i++) begin
      we[i] = enq_ok && (CNT_W'(i) < enq_n);
    end
  end

  iq_storage #(
    .INST_W (INST_W),
    .DEPTH  (DEPTH),
    .ENQ_W  (ENQ_W),
    .DEQ_W  (DEQ_W),
    .PTR_W  (PTR_W)
  ) u_storage (
    .clk   (clk),
    .we    (we),
    .tail  (tail),
    .wdata (enq_data),
    .head  (head),
    .rdata (rdata)
  );

  // Decode view: invalid lanes read as zero.
  always_comb begin
    deq_valid = '0;
    deq_data  = '0;
    for (int i = 0; i < DEQ_W; i++) begin
      deq_valid[i] = cnt > CNT_W'(i);
      if (deq_valid[i]) begin
        deq_data[i*INST_W +: INST_W] =
          rdata[i*INST_W +: INST_W];
      end
    end
  end

  // Pointers and occupancy; flush wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head + PTR_W'(take);
      tail <= tail + PTR_W'(enq_n);
      cnt  <= cnt + enq_n - take;
    end
  end

  // Sticky over-take flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overtake <= 1'b0;
    end else if (!flush && overtake) begin
      err_overtake <= 1'b1;
    end
  end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
Parametrised circular instruction buffer between fetch and dual/N-issue decode. Accepts up to ENQ_W instructions per cycle from the fetch path. Presents the oldest DEQ_W instructions to decode, which retires 0..DEQ_W of them per cycle. Supports all-or-nothing enqueue backpressure and a single-cycle flush for redirects.

Parameters:
INST_W, 32, instruction width in bits
DEPTH, 64, entry count; power of two, >= ENQ_W + DEQ_W
ENQ_W, 2, enqueue lanes per cycle
DEQ_W, 2, dequeue lanes per cycle
CNT_W, $clog2(DEPTH+1), occupancy counter width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  discard all entries this cycle
enq_valid  in  1  enqueue request
enq_count  in  $clog2(ENQ_W+1)  number of valid lanes, lane 0 first (1..ENQ_W)
enq_data  in  ENQ_W*INST_W  lane i at bits [i*INST_W +: INST_W]; lane 0 is oldest
enq_ready  out  1  free entries >= ENQ_W
deq_data  out  DEQ_W*INST_W  lane i = entry head+i (mod DEPTH)
deq_valid  out  DEQ_W  bit i set when count > i
deq_take  in  $clog2(DEQ_W+1)  entries consumed this cycle
count  out  CNT_W  current occupancy
err_overtake  out  1  sticky; deq_take exceeded valid lanes

Behaviour:
- Reset (async assert, sync deassert is caller's job): head=0, tail=0, count=0, err_overtake=0, enq_ready=1, deq_valid=0, deq_data=0. Storage is not reset.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is held explicitly, so full (count==DEPTH) and empty (count==0) are unambiguous.
- enq_ready = (DEPTH - count) >= ENQ_W, from registered count only. Same-cycle dequeues do not raise it.
- Enqueue fires when enq_valid & enq_ready & ~flush. It writes enq_count lanes to tail..tail+enq_count-1, then tail += enq_count. If enq_valid is set while enq_ready=0, nothing is written and the fetch side must hold. enq_count==0 or enq_count>ENQ_W with enq_valid=1 is treated as no-op.
- Dequeue view is combinational from registered state. deq_data lane i is zero when deq_valid[i]=0.
- Enqueued data is visible on deq_data the next cycle. There is no same-cycle bypass.
- eff_take = min(deq_take, count, DEQ_W); head += eff_take.
- If deq_take > number of valid lanes, err_overtake sets and stays set until reset. The take is clamped; no underflow.
- Simultaneous enqueue and dequeue: count_next = count + enq_n - eff_take. Storage is read before write, so a full queue cannot be overwritten.
- flush: next cycle head=tail=0 and count=0. Flush overrides enqueue and dequeue in the same cycle. err_overtake is unaffected.
- Reset asserted mid-operation: immediate return to reset values regardless of pending enq/deq/flush.
- Throughput: sustains ENQ_W in / DEQ_W out per cycle indefinitely when ENQ_W==DEQ_W and count is in steady state.

Decomposition:
- Shared package fetch_pkg: INST_W, default DEPTH/ENQ_W/DEQ_W, a typedef inst_t [0:INST_W-1], and the lane-count widths.
- One sub-module, iq_storage: DEPTH x INST_W register array with ENQ_W write ports (address tail+i, enable per lane) and DEQ_W combinational read ports (address head+i).
- Pointer, count, ready and error logic stay in inst_fetch_queue.

Test Plan:
- Reset: hold rst_n=0 with enq_valid=1 -> count=0, deq_valid=0, deq_data=0, enq_ready=1; after release, one enqueue of {A0,A1} -> next cycle deq_valid=2'b11, lane0=A0, lane1=A1.
- Fill to full (defaults): enqueue 2/cycle, deq_take=0 for 32 cycles -> count=64, enq_ready=0. A 33rd enqueue is dropped and the entries are unchanged.
- Wrap-around: fill 62, drain 62, then enqueue 4 -> entries land at indices 62,63,0,1. deq_data shows them in order; count=4.
- Simultaneous: count=64, enq blocked, deq_take=2 -> count=62, enq_ready=1 next cycle. Then enq 2 + take 2 at once -> count stays 62, FIFO order preserved.
- Flush: count=10, flush=1 with enq_valid=1 and deq_take=2 in the same cycle -> next cycle count=0, deq_valid=0, enq_ready=1.
- Overtake: count=1, deq_take=2 -> head advances 1, count=0, err_overtake=1 and stays 1 through a later flush.
